cci_test_req_throttle: RTL and testbench
========================================

Name: cci_test_req_throttle

Overview:
- Parametrised per-channel request tracker and throttle for the CCI test harness. Sits between the FIU-side MPF interface and the test engine.
- Counts in-flight cache lines per channel from request/response strobes and drives a registered force-almost-full per channel.
- Two selectable modes per channel: active-line cap, or lines-per-window rate limit.
- Also reports current and peak occupancy and sticky accounting errors for CSR readout.

Parameters:
- NUM_CHANNELS, 2, number of independently tracked channels (c0 reads, c1 writes, ...).
- MAX_ACTIVE_LINES, 512, counter saturation point; CNT_W = $clog2(MAX_ACTIVE_LINES)+1.
- WINDOW_W, 16, width of the rate-limit window length.

Ports:
- clk  in  1  block clock.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_en  in  NUM_CHANNELS  per-channel throttle enable; counting runs regardless.
- cfg_mode  in  NUM_CHANNELS  0 = active-line cap, 1 = window rate limit.
- cfg_limit  in  NUM_CHANNELS x CNT_W  per-channel threshold in lines.
- cfg_window  in  WINDOW_W  window length in cycles, shared by all channels.
- cfg_clear  in  1  single-cycle pulse: clears peak, error flags, window state.
- req_valid  in  NUM_CHANNELS  request issued this cycle.
- req_cl_len  in  NUM_CHANNELS x 2  CCI cl_len encoding: 0 = 1 line, 1 = 2 lines, 3 = 4 lines, 2 = illegal.
- rsp_valid  in  NUM_CHANNELS  response retired this cycle.
- rsp_lines  in  NUM_CHANNELS x 3  lines retired by this response, 1..4 (packed write responses).
- force_alm_full  out  NUM_CHANNELS  throttle output, registered.
- active_lines  out  NUM_CHANNELS x CNT_W  current in-flight lines, registered.
- peak_lines  out  NUM_CHANNELS x CNT_W  high-water mark of active_lines.
- err_underflow  out  NUM_CHANNELS  sticky: retire would drive count below 0.
- err_overflow  out  NUM_CHANNELS  sticky: count would exceed MAX_ACTIVE_LINES.
- err_cl_len  out  NUM_CHANNELS  sticky: req_cl_len == 2 seen.

Behaviour:
- Reset: all outputs, counters, window state and error flags go to 0 asynchronously. Release is synchronised to clk internally.
- Reset mid-operation discards all in-flight accounting. No recovery of lost counts.
- Line count per cycle:
  - add = req_valid ? decode(req_cl_len) : 0. Illegal encoding counts as 1 line and sets err_cl_len.
  - sub = rsp_valid ? rsp_lines : 0. rsp_lines of 0 or >4 when valid is clamped to 1..4.
- Active count:
  - next = active + add - sub, computed at CNT_W+1 bits signed.
  - Simultaneous request and response on the same channel in one cycle are both applied.
  - next < 0: load 0 and set err_underflow.
  - next > MAX_ACTIVE_LINES: load MAX_ACTIVE_LINES and set err_overflow.
  - active_lines reflects the cycle's events one clock later.
- peak_lines:
  - Loads next whenever next > peak.
  - cfg_clear loads peak with the current active value, not 0.
  - If cfg_clear coincides with events, the post-event value is loaded.
- Window counter (top level, shared):
  - Free-running, counts 0..W-1, where W = max(cfg_window, 1).
  - Wraps to 0; the wrap cycle is the cycle the count equals W-1.
  - cfg_clear resets it to 0.
- Per-channel window count:
  - Lines issued in the current window, saturating at MAX_ACTIVE_LINES.
  - On wrap it loads this cycle's add (this request belongs to the new window).
  - Otherwise it loads win + add.
- force_alm_full, registered, one cycle after the triggering event:
  - cfg_en = 0: 0.
  - Mode 0: 1 iff next_active >= cfg_limit.
  - Mode 1: 1 iff next_win >= cfg_limit.
  - cfg_limit = 0 with cfg_en = 1: forced 1 continuously.
- Requests arriving while force_alm_full = 1 are still counted. CCI almost-full slack is the requester's responsibility.
- cfg_* changes take effect on the next cycle's comparison. No resynchronisation is applied; cfg is quasi-static in clk domain.

Decomposition:
- Package cci_test_req_throttle_pkg holds:
  - t_cl_len_enc localparams.
  - Function cl_len_to_lines(2b) -> 3b.
  - typedef t_active_cnt [CNT_W-1:0].
  - Error-bit index constants for CSR packing.
- Sub-module cci_test_req_throttle_chan, instantiated NUM_CHANNELS times:
  - Holds the active counter, window counter, peak, errors and compare logic.
  - Takes a window_wrap strobe from the top.
- Top holds the shared window counter and the reset synchroniser.

Test Plan:
- Reset and counting: mode 0, cfg_en = 1, cfg_limit = 8, ch0. Two 4-line requests (cl_len = 3) on consecutive cycles -> active_lines = 4, then 8; force_alm_full rises the cycle after the second request. One rsp_lines = 4 -> active = 4, force falls next cycle; peak_lines = 8.
- Simultaneous events: ch1 active = 5. Same cycle: req cl_len = 1 and rsp_lines = 2 -> active = 5. Same cycle: req cl_len = 0 and rsp_lines = 4 -> active = 2. No errors.
- Underflow: ch0 active = 1, rsp_lines = 3 -> active = 0, err_underflow = 1 and stays sticky. cfg_clear -> err_underflow = 0.
- Rate mode: mode 1, cfg_window = 10, cfg_limit = 4. One 1-line request per cycle from window start -> force asserts the cycle after the 4th request and deasserts the cycle after the wrap. A request on the wrap cycle starts the new window count at 1.
- Edge config:
  - cfg_limit = 0, cfg_en = 1 -> force = 1 with zero traffic.
  - cfg_window = 0 -> wraps every cycle.
  - cl_len = 2 -> counts 1 line, err_cl_len = 1.
- Reset mid-operation: ch0 active = 37, err_overflow set. Assert reset_n = 0 asynchronously between edges -> all outputs read 0 before the next clk edge. Traffic after release counts from 0.

Source files
------------

// File: rtl/cci_test_req_throttle_pkg.sv
// Shared encodings, widths and helpers for the CCI request throttle.
// Error-bit indices fix the CSR packing order of the sticky flags.
package cci_test_req_throttle_pkg;

  localparam int unsigned MAX_ACTIVE_LINES_DFLT = 512;
  localparam int unsigned CNT_W_DFLT            = $clog2(MAX_ACTIVE_LINES_DFLT) + 1;

  typedef logic [CNT_W_DFLT-1:0] t_active_cnt;

  typedef enum logic [1:0] {
    CL_LEN_1       = 2'd0,
    CL_LEN_2       = 2'd1,
    CL_LEN_ILLEGAL = 2'd2,
    CL_LEN_4       = 2'd3
  } t_cl_len_enc;

  localparam int unsigned ERR_UNDERFLOW = 0;
  localparam int unsigned ERR_OVERFLOW  = 1;
  localparam int unsigned ERR_CL_LEN    = 2;
  localparam int unsigned ERR_W         = 3;

  // Illegal encoding is charged as a single line.
  function automatic logic [2:0] cl_len_to_lines(input logic [1:0] enc);
    logic [2:0] lines;
    case (t_cl_len_enc'(enc))
      CL_LEN_1: lines = 3'd1;
      CL_LEN_2: lines = 3'd2;
      CL_LEN_4: lines = 3'd4;
      default:  lines = 3'd1;
    endcase
    return lines;
  endfunction

  function automatic logic cl_len_illegal(input logic [1:0] enc);
    return t_cl_len_enc'(enc) == CL_LEN_ILLEGAL;
  endfunction

  function automatic logic [2:0] clamp_rsp_lines(input logic [2:0] n);
    logic [2:0] lines;
    if (n == 3'd0)      lines = 3'd1;
    else if (n > 3'd4)  lines = 3'd4;
    else                lines = n;
    return lines;
  endfunction

endpackage

// File: rtl/cci_test_req_throttle_chan.sv
// One channel of the throttle: in-flight and per-window line counters,
// high-water mark, sticky accounting errors and the registered almost-full.
module cci_test_req_throttle_chan
  import cci_test_req_throttle_pkg::*;
#(
  parameter int unsigned MAX_ACTIVE_LINES = MAX_ACTIVE_LINES_DFLT,
  parameter int unsigned CNT_W            = $clog2(MAX_ACTIVE_LINES) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_en_i,
  input  logic             cfg_mode_i,
  input  logic [CNT_W-1:0] cfg_limit_i,
  input  logic             cfg_clear_i,
  input  logic             window_wrap_i,
  input  logic             req_valid_i,
  input  logic [1:0]       req_cl_len_i,
  input  logic             rsp_valid_i,
  input  logic [2:0]       rsp_lines_i,
  output logic             force_alm_full_o,
  output logic [CNT_W-1:0] active_lines_o,
  output logic [CNT_W-1:0] peak_lines_o,
  output logic             err_underflow_o,
  output logic             err_overflow_o,
  output logic             err_cl_len_o
);

  localparam logic signed [CNT_W:0] MAX_S = $signed((CNT_W+1)'(MAX_ACTIVE_LINES));
  localparam logic [CNT_W-1:0]      MAX_U = CNT_W'(MAX_ACTIVE_LINES);

  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] peak_q, peak_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             force_q, force_d;

  logic [2:0]              add, sub;
  logic signed [CNT_W:0]   sum;
  logic [CNT_W-1:0]        win_base;
  logic [CNT_W:0]          win_sum;
  logic [ERR_W-1:0]        err_new;

  always_comb begin
    add      = req_valid_i ? cl_len_to_lines(req_cl_len_i) : 3'd0;
    sub      = rsp_valid_i ? clamp_rsp_lines(rsp_lines_i) : 3'd0;
    sum      = $signed({1'b0, active_q})
             + $signed((CNT_W+1)'(add))
             - $signed((CNT_W+1)'(sub));
    err_new  = '0;
    active_d = sum[CNT_W-1:0];
    if (sum < 0) begin
      active_d               = '0;
      err_new[ERR_UNDERFLOW] = 1'b1;
    end else if (sum > MAX_S) begin
      active_d               = MAX_U;
      err_new[ERR_OVERFLOW]  = 1'b1;
    end
    err_new[ERR_CL_LEN] = req_valid_i && cl_len_illegal(req_cl_len_i);

    // A request on the wrap cycle is the first of the new window.
    win_base = window_wrap_i ? '0 : win_q;
    win_sum  = (CNT_W+1)'(win_base) + (CNT_W+1)'(add);
    win_d    = (win_sum > (CNT_W+1)'(MAX_U)) ? MAX_U : win_sum[CNT_W-1:0];

    if (cfg_clear_i)              peak_d = active_d;
    else if (active_d > peak_q)   peak_d = active_d;
    else                          peak_d = peak_q;

    err_d = (cfg_clear_i ? '0 : err_q) | err_new;

    if (!cfg_en_i)        force_d = 1'b0;
    else if (cfg_mode_i)  force_d = (win_d >= cfg_limit_i);
    else                  force_d = (active_d >= cfg_limit_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= '0;
      win_q    <= '0;
      peak_q   <= '0;
      err_q    <= '0;
      force_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      win_q    <= win_d;
      peak_q   <= peak_d;
      err_q    <= err_d;
      force_q  <= force_d;
    end
  end

  assign force_alm_full_o = force_q;
  assign active_lines_o   = active_q;
  assign peak_lines_o     = peak_q;
  assign err_underflow_o  = err_q[ERR_UNDERFLOW];
  assign err_overflow_o   = err_q[ERR_OVERFLOW];
  assign err_cl_len_o     = err_q[ERR_CL_LEN];

endmodule

// File: rtl/cci_test_req_throttle.sv
// Per-channel CCI request tracker/throttle: shared rate-limit window counter,
// reset synchroniser and NUM_CHANNELS channel trackers.
module cci_test_req_throttle
  import cci_test_req_throttle_pkg::*;
#(
  parameter  int unsigned NUM_CHANNELS     = 2,
  parameter  int unsigned MAX_ACTIVE_LINES = MAX_ACTIVE_LINES_DFLT,
  parameter  int unsigned WINDOW_W         = 16,
  localparam int unsigned CNT_W            = $clog2(MAX_ACTIVE_LINES) + 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_CHANNELS-1:0]              cfg_en,
  input  logic [NUM_CHANNELS-1:0]              cfg_mode,
  input  logic [NUM_CHANNELS-1:0][CNT_W-1:0]   cfg_limit,
  input  logic [WINDOW_W-1:0]                  cfg_window,
  input  logic                                 cfg_clear,
  input  logic [NUM_CHANNELS-1:0]              req_valid,
  input  logic [NUM_CHANNELS-1:0][1:0]         req_cl_len,
  input  logic [NUM_CHANNELS-1:0]              rsp_valid,
  input  logic [NUM_CHANNELS-1:0][2:0]         rsp_lines,
  output logic [NUM_CHANNELS-1:0]              force_alm_full,
  output logic [NUM_CHANNELS-1:0][CNT_W-1:0]   active_lines,
  output logic [NUM_CHANNELS-1:0][CNT_W-1:0]   peak_lines,
  output logic [NUM_CHANNELS-1:0]              err_underflow,
  output logic [NUM_CHANNELS-1:0]              err_overflow,
  output logic [NUM_CHANNELS-1:0]              err_cl_len
);

  // Assert asynchronously, release two clocks after reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  logic [WINDOW_W-1:0] win_cnt_q, win_cnt_d;
  logic [WINDOW_W-1:0] win_last;
  logic                win_wrap;
  logic                chan_wrap;

  always_comb begin
    win_last  = (cfg_window == '0) ? '0 : cfg_window - WINDOW_W'(1);
    win_wrap  = (win_cnt_q >= win_last);
    win_cnt_d = (win_wrap || cfg_clear) ? '0 : win_cnt_q + WINDOW_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) win_cnt_q <= '0;
    else            win_cnt_q <= win_cnt_d;
  end

  // cfg_clear restarts the window, so channels treat it like a wrap.
  assign chan_wrap = win_wrap || cfg_clear;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    cci_test_req_throttle_chan #(
      .MAX_ACTIVE_LINES (MAX_ACTIVE_LINES),
      .CNT_W            (CNT_W)
    ) u_chan (
      .clk_i            (clk),
      .rst_ni           (rst_n_int),
      .cfg_en_i         (cfg_en[g]),
      .cfg_mode_i       (cfg_mode[g]),
      .cfg_limit_i      (cfg_limit[g]),
      .cfg_clear_i      (cfg_clear),
      .window_wrap_i    (chan_wrap),
      .req_valid_i      (req_valid[g]),
      .req_cl_len_i     (req_cl_len[g]),
      .rsp_valid_i      (rsp_valid[g]),
      .rsp_lines_i      (rsp_lines[g]),
      .force_alm_full_o (force_alm_full[g]),
      .active_lines_o   (active_lines[g]),
      .peak_lines_o     (peak_lines[g]),
      .err_underflow_o  (err_underflow[g]),
      .err_overflow_o   (err_overflow[g]),
      .err_cl_len_o     (err_cl_len[g])
    );
  end

endmodule

// File: tb/tb_cci_test_req_throttle.sv
// Directed self-checking bench for cci_test_req_throttle (2 channels, 512 lines).
module tb_cci_test_req_throttle;

  localparam int NCH   = 2;
  localparam int CNT_W = 10;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NCH-1:0]            cfg_en, cfg_mode;
  logic [NCH-1:0][CNT_W-1:0] cfg_limit;
  logic [15:0]               cfg_window;
  logic                      cfg_clear;
  logic [NCH-1:0]            req_valid, rsp_valid;
  logic [NCH-1:0][1:0]       req_cl_len;
  logic [NCH-1:0][2:0]       rsp_lines;
  logic [NCH-1:0]            force_alm_full, err_underflow, err_overflow, err_cl_len;
  logic [NCH-1:0][CNT_W-1:0] active_lines, peak_lines;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cci_test_req_throttle #(
    .NUM_CHANNELS     (2),
    .MAX_ACTIVE_LINES (512),
    .WINDOW_W         (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_en         (cfg_en),
    .cfg_mode       (cfg_mode),
    .cfg_limit      (cfg_limit),
    .cfg_window     (cfg_window),
    .cfg_clear      (cfg_clear),
    .req_valid      (req_valid),
    .req_cl_len     (req_cl_len),
    .rsp_valid      (rsp_valid),
    .rsp_lines      (rsp_lines),
    .force_alm_full (force_alm_full),
    .active_lines   (active_lines),
    .peak_lines     (peak_lines),
    .err_underflow  (err_underflow),
    .err_overflow   (err_overflow),
    .err_cl_len     (err_cl_len)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim();
    req_valid  = '0;
    rsp_valid  = '0;
    req_cl_len = '0;
    rsp_lines  = '0;
    cfg_clear  = 1'b0;
  endtask

  task automatic do_reset();
    clear_stim();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic cyc(input logic [1:0] rv, input logic [1:0][1:0] cl,
                     input logic [1:0] sv, input logic [1:0][2:0] rl);
    req_valid  = rv;
    req_cl_len = cl;
    rsp_valid  = sv;
    rsp_lines  = rl;
    tick();
    clear_stim();
  endtask

  task automatic test_reset();
    cfg_en = 2'b11; cfg_mode = 2'b00; cfg_limit = '0; cfg_window = 16'd10;
    clear_stim();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (force_alm_full !== 2'b00) begin errors++; $display("FAIL reset_force got %b exp 00", force_alm_full); end
    checks++;
    if ({active_lines, peak_lines} !== '0) begin errors++; $display("FAIL reset_counts got %h exp 0", {active_lines, peak_lines}); end
    checks++;
    if ({err_underflow, err_overflow, err_cl_len} !== 6'b0) begin errors++; $display("FAIL reset_errs got %b exp 0", {err_underflow, err_overflow, err_cl_len}); end
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_counting();
    cfg_en = 2'b01; cfg_mode = 2'b00; cfg_limit = {10'd8, 10'd8};
    do_reset();
    cyc(2'b01, {2'd0, 2'd3}, 2'b00, '0);
    checks++;
    if (active_lines[0] !== 10'd4) begin errors++; $display("FAIL cnt_first got %0d exp 4", active_lines[0]); end
    checks++;
    if (force_alm_full[0] !== 1'b0) begin errors++; $display("FAIL cnt_force_low got %b exp 0", force_alm_full[0]); end
    cyc(2'b01, {2'd0, 2'd3}, 2'b00, '0);
    checks++;
    if (active_lines[0] !== 10'd8) begin errors++; $display("FAIL cnt_second got %0d exp 8", active_lines[0]); end
    checks++;
    if (force_alm_full[0] !== 1'b1) begin errors++; $display("FAIL cnt_force_rise got %b exp 1", force_alm_full[0]); end
    cyc(2'b00, '0, 2'b01, {3'd0, 3'd4});
    checks++;
    if (active_lines[0] !== 10'd4) begin errors++; $display("FAIL cnt_retire got %0d exp 4", active_lines[0]); end
    checks++;
    if (force_alm_full !== 2'b00) begin errors++; $display("FAIL cnt_force_fall got %b exp 00", force_alm_full); end
    checks++;
    if (peak_lines[0] !== 10'd8) begin errors++; $display("FAIL cnt_peak got %0d exp 8", peak_lines[0]); end
  endtask

  task automatic test_simultaneous();
    cfg_en = 2'b00;
    do_reset();
    cyc(2'b10, {2'd3, 2'd0}, 2'b00, '0);
    cyc(2'b10, {2'd0, 2'd0}, 2'b00, '0);
    checks++;
    if (active_lines[1] !== 10'd5) begin errors++; $display("FAIL sim_setup got %0d exp 5", active_lines[1]); end
    cyc(2'b10, {2'd1, 2'd0}, 2'b10, {3'd2, 3'd0});
    checks++;
    if (active_lines[1] !== 10'd5) begin errors++; $display("FAIL sim_2in2out got %0d exp 5", active_lines[1]); end
    cyc(2'b10, {2'd0, 2'd0}, 2'b10, {3'd4, 3'd0});
    checks++;
    if (active_lines[1] !== 10'd2) begin errors++; $display("FAIL sim_1in4out got %0d exp 2", active_lines[1]); end
    cyc(2'b10, {2'd3, 2'd0}, 2'b00, '0);
    cyc(2'b00, '0, 2'b10, {3'd7, 3'd0});
    checks++;
    if (active_lines[1] !== 10'd2) begin errors++; $display("FAIL sim_clamp_hi got %0d exp 2", active_lines[1]); end
    cyc(2'b00, '0, 2'b10, {3'd0, 3'd0});
    checks++;
    if (active_lines[1] !== 10'd1) begin errors++; $display("FAIL sim_clamp_lo got %0d exp 1", active_lines[1]); end
    checks++;
    if (peak_lines[1] !== 10'd6) begin errors++; $display("FAIL sim_peak got %0d exp 6", peak_lines[1]); end
    checks++;
    if ({err_underflow, err_overflow, err_cl_len} !== 6'b0) begin errors++; $display("FAIL sim_errs got %b exp 0", {err_underflow, err_overflow, err_cl_len}); end
  endtask

  task automatic test_underflow();
    cfg_en = 2'b00;
    do_reset();
    cyc(2'b01, {2'd0, 2'd0}, 2'b00, '0);
    cyc(2'b00, '0, 2'b01, {3'd0, 3'd3});
    checks++;
    if (active_lines[0] !== 10'd0) begin errors++; $display("FAIL uf_active got %0d exp 0", active_lines[0]); end
    checks++;
    if (err_underflow !== 2'b01) begin errors++; $display("FAIL uf_flag got %b exp 01", err_underflow); end
    tick();
    checks++;
    if (err_underflow !== 2'b01) begin errors++; $display("FAIL uf_sticky got %b exp 01", err_underflow); end
    checks++;
    if (peak_lines[0] !== 10'd1) begin errors++; $display("FAIL uf_peak got %0d exp 1", peak_lines[0]); end
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    checks++;
    if (err_underflow !== 2'b00) begin errors++; $display("FAIL uf_clear got %b exp 00", err_underflow); end
    checks++;
    if (peak_lines[0] !== 10'd0) begin errors++; $display("FAIL uf_peak_clear got %0d exp 0", peak_lines[0]); end
  endtask

  task automatic test_rate_mode();
    logic exp_f;
    cfg_en = 2'b01; cfg_mode = 2'b01; cfg_limit = {10'd8, 10'd4}; cfg_window = 16'd10;
    do_reset();
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(2'b01, {2'd0, 2'd0}, 2'b00, '0);
      exp_f = (i >= 3 && i <= 8);
      checks++;
      if (force_alm_full[0] !== exp_f) begin errors++; $display("FAIL rate_win0_%0d got %b exp %b", i, force_alm_full[0], exp_f); end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, {2'd0, 2'd0}, 2'b00, '0);
      exp_f = (i == 2);
      checks++;
      if (force_alm_full[0] !== exp_f) begin errors++; $display("FAIL rate_win1_%0d got %b exp %b", i, force_alm_full[0], exp_f); end
    end
  endtask

  task automatic test_edge_config();
    cfg_en = 2'b11; cfg_mode = 2'b00; cfg_limit = {10'd8, 10'd0}; cfg_window = 16'd10;
    do_reset();
    tick();
    checks++;
    if (force_alm_full !== 2'b01) begin errors++; $display("FAIL edge_limit0 got %b exp 01", force_alm_full); end
    cfg_window = 16'd0; cfg_mode = 2'b01; cfg_limit = {10'd8, 10'd2};
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, {2'd0, 2'd0}, 2'b00, '0);
      checks++;
      if (force_alm_full[0] !== 1'b0) begin errors++; $display("FAIL edge_win0_%0d got %b exp 0", i, force_alm_full[0]); end
    end
    cyc(2'b10, {2'd2, 2'd0}, 2'b00, '0);
    checks++;
    if (active_lines[1] !== 10'd1) begin errors++; $display("FAIL edge_cllen_cnt got %0d exp 1", active_lines[1]); end
    checks++;
    if (err_cl_len !== 2'b10) begin errors++; $display("FAIL edge_cllen_err got %b exp 10", err_cl_len); end
  endtask

  task automatic test_reset_mid();
    cfg_en = 2'b00; cfg_mode = 2'b00; cfg_limit = {10'd8, 10'd8};
    do_reset();
    repeat (128) cyc(2'b01, {2'd0, 2'd3}, 2'b00, '0);
    checks++;
    if (active_lines[0] !== 10'd512 || err_overflow !== 2'b00) begin errors++; $display("FAIL ovf_at_max got %0d/%b exp 512/00", active_lines[0], err_overflow); end
    cyc(2'b01, {2'd0, 2'd3}, 2'b00, '0);
    checks++;
    if (active_lines[0] !== 10'd512 || err_overflow !== 2'b01) begin errors++; $display("FAIL ovf_sat got %0d/%b exp 512/01", active_lines[0], err_overflow); end
    repeat (118) cyc(2'b00, '0, 2'b01, {3'd0, 3'd4});
    cyc(2'b00, '0, 2'b01, {3'd0, 3'd3});
    checks++;
    if (active_lines[0] !== 10'd37) begin errors++; $display("FAIL mid_active got %0d exp 37", active_lines[0]); end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (active_lines[0] !== 10'd0 || peak_lines[0] !== 10'd0) begin errors++; $display("FAIL mid_async_cnt got %0d/%0d exp 0/0", active_lines[0], peak_lines[0]); end
    checks++;
    if (err_overflow !== 2'b00) begin errors++; $display("FAIL mid_async_err got %b exp 00", err_overflow); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) tick();
    cyc(2'b01, {2'd0, 2'd1}, 2'b00, '0);
    checks++;
    if (active_lines[0] !== 10'd2) begin errors++; $display("FAIL mid_restart got %0d exp 2", active_lines[0]); end
  endtask

  initial begin
    reset_n = 1'b0;
    clear_stim();
    test_reset();
    test_counting();
    test_simultaneous();
    test_underflow();
    test_rate_mode();
    test_edge_config();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
